// File: rtl/commit_stage_nway_if.sv
// Lane bus between the MEM stage and the N-issue commit register.
// master = upstream producer / WB consumer side, slave = commit stage.
interface commit_stage_nway_if #(
   parameter int LANES  = 2,
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RA_W   = 5,
   parameter int CNT_W  = 32,
   parameter int LW     = $clog2(LANES) + 1
);
   logic [LANES-1:0]        valid_i;
   logic [LANES*PC_W-1:0]   pc_i;
   logic [LANES-1:0]        we_i;
   logic [LANES*RA_W-1:0]   waddr_i;
   logic [LANES*DATA_W-1:0] wdata_i;
   logic [LW-1:0]           sfx_lane_i;
   logic                    whilo_i;
   logic [DATA_W-1:0]       hi_i;
   logic [DATA_W-1:0]       lo_i;
   logic                    llbit_we_i;
   logic                    llbit_i;
   logic                    cp0_we_i;
   logic [RA_W-1:0]         cp0_waddr_i;
   logic [2:0]              cp0_wsel_i;
   logic [DATA_W-1:0]       cp0_wdata_i;

   logic [LANES-1:0]        commit_o;
   logic [LANES*PC_W-1:0]   pc_o;
   logic [LANES-1:0]        we_o;
   logic [LANES*RA_W-1:0]   waddr_o;
   logic [LANES*DATA_W-1:0] wdata_o;
   logic                    whilo_o;
   logic [DATA_W-1:0]       hi_o;
   logic [DATA_W-1:0]       lo_o;
   logic                    llbit_we_o;
   logic                    llbit_o;
   logic                    cp0_we_o;
   logic [RA_W-1:0]         cp0_waddr_o;
   logic [2:0]              cp0_wsel_o;
   logic [DATA_W-1:0]       cp0_wdata_o;
   logic [CNT_W-1:0]        retire_cnt_o;

   modport master (
      output valid_i, pc_i, we_i, waddr_i, wdata_i, sfx_lane_i,
             whilo_i, hi_i, lo_i, llbit_we_i, llbit_i,
             cp0_we_i, cp0_waddr_i, cp0_wsel_i, cp0_wdata_i,
      input  commit_o, pc_o, we_o, waddr_o, wdata_o,
             whilo_o, hi_o, lo_o, llbit_we_o, llbit_o,
             cp0_we_o, cp0_waddr_o, cp0_wsel_o, cp0_wdata_o, retire_cnt_o
   );

   modport slave (
      input  valid_i, pc_i, we_i, waddr_i, wdata_i, sfx_lane_i,
             whilo_i, hi_i, lo_i, llbit_we_i, llbit_i,
             cp0_we_i, cp0_waddr_i, cp0_wsel_i, cp0_wdata_i,
      output commit_o, pc_o, we_o, waddr_o, wdata_o,
             whilo_o, hi_o, lo_o, llbit_we_o, llbit_o,
             cp0_we_o, cp0_waddr_o, cp0_wsel_o, cp0_wdata_o, retire_cnt_o
   );
endinterface

// File: rtl/commit_stage_nway.sv
// MEM->WB commit register for an N-issue in-order MIPS pipeline: precise
// per-lane exception kill, same-cycle WAW squash, $0 write drop, retire counter.
module commit_stage_nway #(
   parameter int LANES  = 2,
   parameter int DATA_W = 32,
   parameter int PC_W   = 32,
   parameter int RA_W   = 5,
   parameter int CNT_W  = 32,
   parameter int LW     = $clog2(LANES) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stall_self,
   input  logic          stall_next,
   input  logic          flush,
   input  logic          flush_cause,
   input  logic [LW-1:0] exc_lane_i,
   commit_stage_nway_if.slave bus
);

   typedef enum logic [1:0] {M_CAPTURE, M_EXC, M_BUBBLE, M_HOLD} mode_t;

   mode_t                   mode;
   logic [LANES-1:0]        alive;
   logic [LANES-1:0]        we_n;
   logic [LANES*PC_W-1:0]   pc_n;
   logic [LANES*RA_W-1:0]   waddr_n;
   logic [LANES*DATA_W-1:0] wdata_n;
   logic                    sfx_ok;
   logic                    fx_en;
   logic                    hilo_en;
   logic                    whilo_n;
   logic [DATA_W-1:0]       hi_n;
   logic [DATA_W-1:0]       lo_n;
   logic                    llbit_we_n;
   logic                    llbit_n;
   logic                    cp0_we_n;
   logic [RA_W-1:0]         cp0_waddr_n;
   logic [2:0]              cp0_wsel_n;
   logic [DATA_W-1:0]       cp0_wdata_n;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_n;

   always_comb begin
      mode = M_CAPTURE;
      if (flush && flush_cause)
         mode = M_EXC;
      else if (stall_self)
         mode = stall_next ? M_HOLD : M_BUBBLE;

      // lanes at or above the excepting lane are younger and must not retire
      for (int unsigned k = 0; k < LANES; k++)
         alive[k] = bus.valid_i[k] &&
                    (mode == M_CAPTURE || (mode == M_EXC && k < 32'(exc_lane_i)));

      sfx_ok = 1'b0;
      for (int unsigned k = 0; k < LANES; k++)
         if (32'(bus.sfx_lane_i) == k && bus.valid_i[k])
            sfx_ok = 1'b1;

      we_n    = '0;
      pc_n    = '0;
      waddr_n = '0;
      wdata_n = '0;
      cnt_n   = cnt_q;
      for (int unsigned k = 0; k < LANES; k++) begin
         if (alive[k]) begin
            pc_n[k*PC_W +: PC_W]       = bus.pc_i[k*PC_W +: PC_W];
            waddr_n[k*RA_W +: RA_W]    = bus.waddr_i[k*RA_W +: RA_W];
            wdata_n[k*DATA_W +: DATA_W] = bus.wdata_i[k*DATA_W +: DATA_W];
            we_n[k] = bus.we_i[k] && (bus.waddr_i[k*RA_W +: RA_W] != '0);
            cnt_n   = cnt_n + CNT_W'(1);
         end
         for (int unsigned j = k + 1; j < LANES; j++)
            if (alive[j] && bus.we_i[j] &&
                bus.waddr_i[j*RA_W +: RA_W] == bus.waddr_i[k*RA_W +: RA_W])
               we_n[k] = 1'b0;
      end

      fx_en   = (mode == M_CAPTURE) && sfx_ok;
      hilo_en = fx_en || (mode == M_EXC && sfx_ok && bus.sfx_lane_i < exc_lane_i);

      whilo_n     = hilo_en && bus.whilo_i;
      hi_n        = hilo_en ? bus.hi_i : '0;
      lo_n        = hilo_en ? bus.lo_i : '0;
      llbit_we_n  = fx_en && bus.llbit_we_i;
      llbit_n     = fx_en && bus.llbit_i;
      cp0_we_n    = fx_en && bus.cp0_we_i;
      cp0_waddr_n = fx_en ? bus.cp0_waddr_i : '0;
      cp0_wsel_n  = fx_en ? bus.cp0_wsel_i : '0;
      cp0_wdata_n = fx_en ? bus.cp0_wdata_i : '0;
   end

   // bubble needs no special case: alive and all side-effect enables are 0 there
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.commit_o    <= '0;
         bus.we_o        <= '0;
         bus.pc_o        <= '0;
         bus.waddr_o     <= '0;
         bus.wdata_o     <= '0;
         bus.whilo_o     <= 1'b0;
         bus.hi_o        <= '0;
         bus.lo_o        <= '0;
         bus.llbit_we_o  <= 1'b0;
         bus.llbit_o     <= 1'b0;
         bus.cp0_we_o    <= 1'b0;
         bus.cp0_waddr_o <= '0;
         bus.cp0_wsel_o  <= '0;
         bus.cp0_wdata_o <= '0;
         cnt_q           <= '0;
      end else if (mode != M_HOLD) begin
         bus.commit_o    <= alive;
         bus.we_o        <= we_n;
         bus.pc_o        <= pc_n;
         bus.waddr_o     <= waddr_n;
         bus.wdata_o     <= wdata_n;
         bus.whilo_o     <= whilo_n;
         bus.hi_o        <= hi_n;
         bus.lo_o        <= lo_n;
         bus.llbit_we_o  <= llbit_we_n;
         bus.llbit_o     <= llbit_n;
         bus.cp0_we_o    <= cp0_we_n;
         bus.cp0_waddr_o <= cp0_waddr_n;
         bus.cp0_wsel_o  <= cp0_wsel_n;
         bus.cp0_wdata_o <= cp0_wdata_n;
         cnt_q           <= cnt_n;
      end
   end

   assign bus.retire_cnt_o = cnt_q;

endmodule

// File: tb/tb_commit_stage_nway.sv
// Bench for commit_stage_nway: a 2-lane/32-bit-counter and a 4-lane/4-bit-counter
// instance share one directed stimulus and are checked against a lane-level model.
module tb_commit_stage_nway;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic       stall_self = 1'b0, stall_next = 1'b0, flush = 1'b0, flush_cause = 1'b0;
   logic [2:0] exc_lane = '0;
   logic [3:0] valid = '0, we = '0;
   logic [3:0][31:0] pc = '0, wdata = '0;
   logic [3:0][4:0]  waddr = '0;
   logic [2:0]  sfx = '0;
   logic        whilo = 1'b0, llwe = 1'b0, ll = 1'b0, cp0we = 1'b0;
   logic [31:0] hi = '0, lo = '0, cp0d = '0;
   logic [4:0]  cp0a = '0;
   logic [2:0]  cp0s = '0;

   commit_stage_nway_if #(.LANES(2)) ia ();
   commit_stage_nway_if #(.LANES(4), .CNT_W(4)) ib ();

   assign ia.valid_i = valid[1:0];      assign ib.valid_i = valid;
   assign ia.we_i    = we[1:0];         assign ib.we_i    = we;
   assign ia.pc_i    = pc[1:0];         assign ib.pc_i    = pc;
   assign ia.waddr_i = waddr[1:0];      assign ib.waddr_i = waddr;
   assign ia.wdata_i = wdata[1:0];      assign ib.wdata_i = wdata;
   assign ia.sfx_lane_i = sfx[1:0];     assign ib.sfx_lane_i = sfx;
   assign ia.whilo_i = whilo;           assign ib.whilo_i = whilo;
   assign ia.hi_i = hi;                 assign ib.hi_i = hi;
   assign ia.lo_i = lo;                 assign ib.lo_i = lo;
   assign ia.llbit_we_i = llwe;         assign ib.llbit_we_i = llwe;
   assign ia.llbit_i = ll;              assign ib.llbit_i = ll;
   assign ia.cp0_we_i = cp0we;          assign ib.cp0_we_i = cp0we;
   assign ia.cp0_waddr_i = cp0a;        assign ib.cp0_waddr_i = cp0a;
   assign ia.cp0_wsel_i = cp0s;         assign ib.cp0_wsel_i = cp0s;
   assign ia.cp0_wdata_i = cp0d;        assign ib.cp0_wdata_i = cp0d;

   commit_stage_nway #(.LANES(2)) dut_a (
      .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next),
      .flush(flush), .flush_cause(flush_cause), .exc_lane_i(exc_lane[1:0]), .bus(ia));

   commit_stage_nway #(.LANES(4), .CNT_W(4)) dut_b (
      .clk(clk), .rst(rst), .stall_self(stall_self), .stall_next(stall_next),
      .flush(flush), .flush_cause(flush_cause), .exc_lane_i(exc_lane), .bus(ib));

   typedef struct packed {
      logic [3:0]       commit;
      logic [3:0]       we;
      logic [3:0][31:0] pc;
      logic [3:0][4:0]  waddr;
      logic [3:0][31:0] wdata;
      logic             whilo;
      logic [31:0]      hi;
      logic [31:0]      lo;
      logic             llwe;
      logic             ll;
      logic             cp0we;
      logic [4:0]       cp0a;
      logic [2:0]       cp0s;
      logic [31:0]      cp0d;
      logic [31:0]      cnt;
   } exp_t;

   // Lane-level model: n lanes, cw-bit counter, exc/sfx seen through LW bits.
   function automatic exp_t model(exp_t prev, int n, int cw);
      exp_t e = '0;
      int   exc, s, limit, retired;
      bit   exc_fl, sok, hok, fok, younger;
      if (rst) return '0;
      exc_fl = flush && flush_cause;
      if (!exc_fl && stall_self && stall_next) return prev;
      if (!exc_fl && stall_self) begin
         e.cnt = prev.cnt;
         return e;
      end
      exc   = (n == 2) ? int'(exc_lane[1:0]) : int'(exc_lane);
      s     = (n == 2) ? int'(sfx[1:0]) : int'(sfx);
      limit = exc_fl ? exc : n;
      retired = 0;
      for (int k = 0; k < n; k++)
         if (valid[k] && k < limit) begin
            e.commit[k] = 1'b1;
            e.pc[k] = pc[k];
            e.waddr[k] = waddr[k];
            e.wdata[k] = wdata[k];
            retired++;
         end
      for (int k = 0; k < n; k++) begin
         younger = 1'b0;
         for (int j = k + 1; j < n; j++)
            if (e.commit[j] && we[j] && waddr[j] == waddr[k]) younger = 1'b1;
         e.we[k] = e.commit[k] && we[k] && waddr[k] != 5'd0 && !younger;
      end
      sok = (s < n) && valid[s];
      hok = sok && (!exc_fl || s < exc);
      fok = sok && !exc_fl;
      e.whilo = hok && whilo;
      e.hi    = hok ? hi : '0;
      e.lo    = hok ? lo : '0;
      e.llwe  = fok && llwe;
      e.ll    = fok && ll;
      e.cp0we = fok && cp0we;
      e.cp0a  = fok ? cp0a : '0;
      e.cp0s  = fok ? cp0s : '0;
      e.cp0d  = fok ? cp0d : '0;
      e.cnt   = 32'((longint'(prev.cnt) + longint'(retired)) & ((64'd1 << cw) - 64'd1));
      return e;
   endfunction

   exp_t ea = '0, eb = '0;
   bit   model_on = 1'b0;

   always @(posedge clk) begin
      ea <= model(ea, 2, 32);
      eb <= model(eb, 4, 4);
      model_on <= 1'b1;
   end

   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (model_on) begin
         chk("a.commit_we", 256'({ia.commit_o, ia.we_o}), 256'({ea.commit[1:0], ea.we[1:0]}));
         chk("a.pc", 256'(ia.pc_o), 256'(ea.pc[1:0]));
         chk("a.waddr_wdata", 256'({ia.waddr_o, ia.wdata_o}), 256'({ea.waddr[1:0], ea.wdata[1:0]}));
         chk("a.side", 256'({ia.whilo_o, ia.hi_o, ia.lo_o, ia.llbit_we_o, ia.llbit_o, ia.cp0_we_o,
                             ia.cp0_waddr_o, ia.cp0_wsel_o, ia.cp0_wdata_o}),
                       256'({ea.whilo, ea.hi, ea.lo, ea.llwe, ea.ll, ea.cp0we, ea.cp0a, ea.cp0s, ea.cp0d}));
         chk("a.cnt", 256'(ia.retire_cnt_o), 256'(ea.cnt));
         chk("b.commit_we", 256'({ib.commit_o, ib.we_o}), 256'({eb.commit, eb.we}));
         chk("b.pc", 256'(ib.pc_o), 256'(eb.pc));
         chk("b.waddr_wdata", 256'({ib.waddr_o, ib.wdata_o}), 256'({eb.waddr, eb.wdata}));
         chk("b.side", 256'({ib.whilo_o, ib.hi_o, ib.lo_o, ib.llbit_we_o, ib.llbit_o, ib.cp0_we_o,
                             ib.cp0_waddr_o, ib.cp0_wsel_o, ib.cp0_wdata_o}),
                       256'({eb.whilo, eb.hi, eb.lo, eb.llwe, eb.ll, eb.cp0we, eb.cp0a, eb.cp0s, eb.cp0d}));
         chk("b.cnt", 256'(ib.retire_cnt_o), 256'(eb.cnt[3:0]));
      end
   end

   task automatic idle();
      stall_self = 0; stall_next = 0; flush = 0; flush_cause = 0; exc_lane = '0;
      valid = '0; we = '0; pc = '0; waddr = '0; wdata = '0; sfx = '0;
      whilo = 0; hi = '0; lo = '0; llwe = 0; ll = 0; cp0we = 0; cp0a = '0; cp0s = '0; cp0d = '0;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      step(); step();
      chk("lit.reset_commit", 256'(ia.commit_o), 256'(0));
      chk("lit.reset_cnt", 256'(ia.retire_cnt_o), 256'(0));
      rst = 1'b0;

      // two independent writes
      valid = 4'b0011; we = 4'b0011; waddr[0] = 5'd7; waddr[1] = 5'd3;
      wdata[0] = 32'hA; wdata[1] = 32'hB; pc[0] = 32'h100; pc[1] = 32'h104;
      step();
      chk("lit.t1_commit", 256'(ia.commit_o), 256'(2'b11));
      chk("lit.t1_we", 256'(ia.we_o), 256'(2'b11));
      chk("lit.t1_wdata", 256'(ia.wdata_o), 256'(64'h0000000B_0000000A));
      chk("lit.t1_cnt", 256'(ia.retire_cnt_o), 256'(2));

      // same-cycle WAW: youngest wins
      waddr[0] = 5'd9; waddr[1] = 5'd9; wdata[0] = 32'h11; wdata[1] = 32'h22;
      step();
      chk("lit.t2_waw_we", 256'(ia.we_o), 256'(2'b10));
      chk("lit.t2_waw_data", 256'(ia.wdata_o[63:32]), 256'(32'h22));

      // write to $0 dropped but lane still retires
      waddr[0] = 5'd0; waddr[1] = 5'd5;
      step();
      chk("lit.t2_r0_we", 256'(ia.we_o), 256'(2'b10));
      chk("lit.t2_r0_commit", 256'(ia.commit_o), 256'(2'b11));

      // exception on lane 1
      waddr[0] = 5'd7; waddr[1] = 5'd3;
      flush = 1; flush_cause = 1; exc_lane = 3'd1; sfx = 3'd0;
      whilo = 1; hi = 32'h1234; lo = 32'h5678; llwe = 1; ll = 1;
      cp0we = 1; cp0a = 5'd12; cp0s = 3'd1; cp0d = 32'hDEAD;
      step();
      chk("lit.t3_commit", 256'(ia.commit_o), 256'(2'b01));
      chk("lit.t3_whilo", 256'(ia.whilo_o), 256'(1));
      chk("lit.t3_cp0we", 256'(ia.cp0_we_o), 256'(0));
      chk("lit.t3_cp0d", 256'(ia.cp0_wdata_o), 256'(0));
      chk("lit.t3_cnt", 256'(ia.retire_cnt_o), 256'(7));

      exc_lane = 3'd0;
      step();
      chk("lit.t3_kill_commit", 256'(ia.commit_o), 256'(0));
      chk("lit.t3_kill_whilo", 256'(ia.whilo_o), 256'(0));
      chk("lit.t3_kill_cnt", 256'(ia.retire_cnt_o), 256'(7));

      // capture with side effects, then hold while inputs change
      flush = 0; flush_cause = 0;
      step();
      chk("lit.t4_cp0we", 256'(ia.cp0_we_o), 256'(1));
      chk("lit.t4_cnt", 256'(ia.retire_cnt_o), 256'(9));
      stall_self = 1; stall_next = 1; valid = '0; cp0we = 0;
      step();
      chk("lit.t4_hold_commit", 256'(ia.commit_o), 256'(2'b11));
      chk("lit.t4_hold_cp0we", 256'(ia.cp0_we_o), 256'(1));
      chk("lit.t4_hold_cnt", 256'(ia.retire_cnt_o), 256'(9));

      // reset during hold
      rst = 1;
      step();
      chk("lit.t6_commit", 256'(ia.commit_o), 256'(0));
      chk("lit.t6_cp0we", 256'(ia.cp0_we_o), 256'(0));
      chk("lit.t6_cnt", 256'(ia.retire_cnt_o), 256'(0));
      rst = 0;

      // two captures, then non-exception flush under stall_self -> bubble
      idle();
      valid = 4'b0011; we = 4'b0011; waddr[0] = 5'd1; waddr[1] = 5'd2;
      wdata[0] = 32'hC0; wdata[1] = 32'hC1; whilo = 1; sfx = 3'd1;
      step(); step();
      chk("lit.t4_pre_cnt", 256'(ia.retire_cnt_o), 256'(4));
      stall_self = 1; stall_next = 0; flush = 1; flush_cause = 0;
      step();
      chk("lit.t4_bubble_commit", 256'(ia.commit_o), 256'(0));
      chk("lit.t4_bubble_we", 256'(ia.we_o), 256'(0));
      chk("lit.t4_bubble_whilo", 256'(ia.whilo_o), 256'(0));
      chk("lit.t4_bubble_cnt", 256'(ia.retire_cnt_o), 256'(4));

      // exception flush wins over a full stall; 4-lane kill at lane 2
      stall_self = 1; stall_next = 1; flush = 1; flush_cause = 1; exc_lane = 3'd2;
      valid = 4'b1111; we = 4'b1111;
      waddr[2] = 5'd3; waddr[3] = 5'd4; wdata[2] = 32'hC2; wdata[3] = 32'hC3;
      step();
      chk("lit.t5_b_commit", 256'(ib.commit_o), 256'(4'b0011));
      chk("lit.t5_b_cnt", 256'(ib.retire_cnt_o), 256'(6));
      chk("lit.t5_a_commit", 256'(ia.commit_o), 256'(2'b11));

      // exc_lane beyond LANES on the 2-lane build keeps all lanes
      stall_self = 0; stall_next = 0; exc_lane = 3'd3; sfx = 3'd1;
      step();
      chk("lit.excbig_a_commit", 256'(ia.commit_o), 256'(2'b11));
      chk("lit.excbig_a_whilo", 256'(ia.whilo_o), 256'(1));
      chk("lit.excbig_b_commit", 256'(ib.commit_o), 256'(4'b0111));

      // side-effect lane out of range or invalid
      flush = 0; flush_cause = 0; valid = 4'b0011; sfx = 3'd2; cp0we = 1; llwe = 1;
      step();
      chk("lit.sfx_oob_cp0", 256'(ia.cp0_we_o), 256'(0));
      chk("lit.sfx_inv_b_cp0", 256'(ib.cp0_we_o), 256'(0));

      // three-way WAW on 4 lanes, lane 3 writes $0
      valid = 4'b1111; we = 4'b1111; cp0we = 0; llwe = 0;
      waddr[0] = 5'd4; waddr[1] = 5'd4; waddr[2] = 5'd4; waddr[3] = 5'd0;
      step();
      chk("lit.waw4_b_we", 256'(ib.we_o), 256'(4'b0100));
      chk("lit.waw4_a_we", 256'(ia.we_o), 256'(2'b10));

      // counter wrap on the 4-bit build
      rst = 1;
      step();
      rst = 0;
      idle();
      valid = 4'b1111;
      step(); step(); step();
      valid = 4'b0111;
      step();
      chk("lit.wrap_pre", 256'(ib.retire_cnt_o), 256'(15));
      valid = 4'b0011;
      step();
      chk("lit.wrap_post", 256'(ib.retire_cnt_o), 256'(1));
      chk("lit.wrap_a_cnt", 256'(ia.retire_cnt_o), 256'(10));

      idle();
      step();
      #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/commit_stage_nway.md
Name: commit_stage_nway

Overview:
Parametrised MEM->WB commit register for an N-issue in-order MIPS pipeline. It generalises the dual-issue commit stage to LANES lanes. It adds per-lane precise exception kill and same-cycle write-after-write squash, and drops writes to $0. It also keeps a retired-instruction counter. Outputs drive the regfile write ports, the HI/LO unit, the LLbit register and CP0.

Parameters:
LANES, 2, number of issue lanes; lane 0 is the oldest instruction.
DATA_W, 32, register and data width.
PC_W, 32, PC width.
RA_W, 5, register address width.
CNT_W, 32, retire counter width.
LW, $clog2(LANES)+1, width of lane-index fields (derived; can hold LANES).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall_self  in  1  hold request for this stage
stall_next  in  1  hold request for the WB consumer
flush  in  1  pipeline flush
flush_cause  in  1  1 = exception, 0 = other (ignored here)
exc_lane_i  in  LW  index of the excepting lane; valid when flush&flush_cause
valid_i  in  LANES  lane carries an instruction
pc_i  in  LANES*PC_W  per-lane PC, lane k at [k*PC_W +: PC_W]
we_i  in  LANES  per-lane GPR write enable
waddr_i  in  LANES*RA_W  per-lane GPR address
wdata_i  in  LANES*DATA_W  per-lane GPR data
sfx_lane_i  in  LW  lane that owns the hi/lo/LL/cp0 side effects
whilo_i  in  1  HI/LO write enable; hi_i, lo_i in DATA_W each
llbit_we_i, llbit_i  in  1 each  LLbit write
cp0_we_i  in  1; cp0_waddr_i in RA_W; cp0_wsel_i in 3; cp0_wdata_i in DATA_W
commit_o  out  LANES  lane retired this cycle
pc_o, we_o, waddr_o, wdata_o  out  same widths as inputs; registered
whilo_o, hi_o, lo_o, llbit_we_o, llbit_o, cp0_we_o, cp0_waddr_o, cp0_wsel_o, cp0_wdata_o  out  registered
retire_cnt_o  out  CNT_W  total lanes retired since reset

Behaviour:
- All outputs are registered with 1-cycle latency; all updates happen on posedge clk.
- Reset: every output goes to 0, including cp0_we_o=0, commit_o=0 and retire_cnt_o=0. Reset overrides all other inputs, including mid-stall.
- Priority: rst > exception flush > stall. flush with flush_cause=0 has no effect; the stall logic applies.
- Survival mask alive[k]:
  - Normal capture: alive[k] = valid_i[k].
  - Exception flush: alive[k] = valid_i[k] & (k < exc_lane_i). exc_lane_i=0 kills all lanes. Any exc_lane_i >= LANES keeps all valid lanes.
- Exception flush is a capture even if stall_self=1.
  - Surviving lanes commit.
  - whilo is kept only if sfx_lane_i < exc_lane_i.
  - LLbit and cp0 writes are always dropped: llbit_we_o=0, cp0_we_o=0, and their data fields go to 0.
- Stall modes when there is no exception flush:
  - stall_self=0: capture.
  - stall_self=1 and stall_next=0: insert a bubble. All enables, commit_o and data outputs go to 0.
  - stall_self=1 and stall_next=1: hold all outputs; the counter is unchanged.
- Capture, per lane k:
  - commit_o[k] = alive[k].
  - we_o[k] = alive[k] & we_i[k] & (waddr!=0) & no younger surviving lane j>k writing the same nonzero waddr (WAW squash; the youngest wins).
  - pc_o, waddr_o and wdata_o pass through for alive lanes; they are 0 for dead lanes.
- Side effects on normal capture: whilo, llbit and cp0 are enabled only if sfx_lane_i < LANES and valid_i[sfx_lane_i]=1.
- Counter: retire_cnt_o += popcount(commit mask) on each capture, including exception captures. It wraps modulo 2^CNT_W and is not incremented on bubble or hold.
- No combinational path from any input to any output.

Test Plan:
1. Reset, then LANES=2, valid=11, we=11, waddr={7,3}, data={A,B}, no stall -> next cycle commit_o=11, we_o=11, retire_cnt_o=2.
2. Both lanes write reg 9 with data {lane0=0x11, lane1=0x22} -> we_o=10 (lane1 only), wdata lane1=0x22; lane0 write to reg 0 -> we_o[0]=0 but commit_o[0]=1.
3. flush=1, cause=1, exc_lane=1, sfx_lane=0, whilo=1, cp0_we=1 -> commit_o=01, whilo_o=1, cp0_we_o=0, counter +1. Repeat with exc_lane=0 -> all outputs 0, counter unchanged.
4. stall_self=1, stall_next=0 -> bubble, all enables 0. stall_self=stall_next=1 -> outputs equal the previous cycle's values. flush with cause=0 while stall_self=1 -> still a bubble or hold.
5. LANES=4 build: exc_lane=2 with valid=1111 -> commit_o=0011, counter +2. Preload counter to 2^CNT_W-1 (CNT_W=4 build), retire 2 lanes -> retire_cnt_o=1.
6. rst asserted during a hold with cp0_we_o=1 -> next cycle all outputs 0, cp0_we_o=0, retire_cnt_o=0.
